lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns EX-stage memory requests into single word-aligned
// bus transactions with byte enables, lane replication, load extension and a bus timeout.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        access_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic               load_valid_q, load_valid_d;
    logic [31:0]        load_data_q, load_data_d;
    logic [4:0]         load_rd_q, load_rd_d;
    logic               access_err_q, access_err_d;
    logic               bus_err_q, bus_err_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;

    logic               req_c;
    logic               legal_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        lane_c;
    logic [31:0]        ext_c;

    // Request decode: legality, byte enables and lane-replicated store data
    always_comb begin
        req_c   = mem_read | mem_write;
        legal_c = 1'b0;
        be_c    = 4'b0000;
        wdata_c = '0;
        case (funct3)
            3'b000, 3'b100: begin
                legal_c = 1'b1;
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                legal_c = ~addr[0];
                be_c    = 4'b0011 << addr[1:0];
                wdata_c = {2{wdata[15:0]}};
            end
            3'b010: begin
                legal_c = (addr[1:0] == 2'b00);
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension using the captured size and offset
    always_comb begin
        lane_c = bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ext_c = {24'd0, lane_c[7:0]};
            3'b101:  ext_c = {16'd0, lane_c[15:0]};
            default: ext_c = lane_c;
        endcase
    end

    assign stall = ~rst & (((state_q == S_IDLE) & req_c & legal_c) | (state_q == S_REQ));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        load_rd_d    = load_rd_q;
        access_err_d = 1'b0;
        bus_err_d    = 1'b0;
        funct3_d     = funct3_q;
        off_d        = off_q;
        case (state_q)
            S_IDLE: begin
                if (req_c && legal_c) begin
                    state_d     = S_REQ;
                    wait_cnt_d  = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write & ~mem_read;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_c;
                    bus_wdata_d = mem_read ? 32'd0 : wdata_c;
                    load_rd_d   = rd;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                end else if (req_c) begin
                    access_err_d = 1'b1;
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle takes priority over the timeout
                if (bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = ext_c;
                    end
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            load_rd_q    <= '0;
            access_err_q <= 1'b0;
            bus_err_q    <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            load_rd_q    <= load_rd_d;
            access_err_q <= access_err_d;
            bus_err_q    <= bus_err_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign load_rd    = load_rd_q;
    assign access_err = access_err_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed and random accesses checked against an
// arithmetic model of lane selection, byte enables, extension and timeout.
module tb_lsu_bus_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [4:0]  rd = '0;
    logic        stall, load_valid, access_err, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [4:0]  load_rd;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd), .stall(stall),
        .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
        .access_err(access_err), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; rd = '0;
    endtask

    // One access from an IDLE cycle; ack_at = REQ cycle index of ack (>= TO means never)
    task automatic do_access(input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rdn, input int ack_at,
                             input logic [31:0] rdata, input string name);
        int size, off, k;
        bit legal, done, acked;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld, mask;
        off  = int'(a[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                && (off % size == 0);
        exp_be = (size == 4) ? 4'hF : 4'(((size == 2) ? 3 : 1) << off);
        if (r)              exp_wd = 32'd0;
        else if (size == 1) exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        else                exp_wd = wd;
        exp_ld = rdata >> (8 * off);
        if (size < 4) begin
            mask   = (32'd1 << (8 * size)) - 32'd1;
            exp_ld = exp_ld & mask;
            if (!f3[2] && exp_ld > (mask >> 1)) exp_ld = exp_ld - mask - 32'd1;
        end

        mem_read = r; mem_write = w; funct3 = f3; addr = a; wdata = wd; rd = rdn;
        #1;
        tests++;
        if (stall !== ((r | w) & legal)) begin
            fails++; $display("FAIL %s/accept_stall: got %b want %b", name, stall, (r | w) & legal);
        end
        step();
        idle_inputs();
        if (!(r | w) || !legal) begin
            tests++;
            if ({access_err, bus_req, stall} !== {r | w, 2'b00}) begin
                fails++; $display("FAIL %s/reject: got err,req,stall=%b want %b", name,
                                  {access_err, bus_req, stall}, {r | w, 2'b00});
            end
            step();
            tests++;
            if (access_err !== 1'b0) begin
                fails++; $display("FAIL %s/err_pulse: got %b want 0", name, access_err);
            end
            return;
        end

        k = 0; done = 0; acked = 0;
        while (!done && k < int'(TO) + 2) begin
            tests++;
            if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall} !==
                {1'b1, w & ~r, a & ~32'h3, exp_be, exp_wd, 1'b1}) begin
                fails++;
                $display("FAIL %s/req k=%0d: got req=%b we=%b addr=%h be=%b wd=%h stall=%b want 1 %b %h %b %h 1",
                         name, k, bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall,
                         w & ~r, a & ~32'h3, exp_be, exp_wd);
            end
            if (k == ack_at) begin
                bus_ack = 1'b1; bus_rdata = rdata; acked = 1; done = 1;
            end else begin
                bus_rdata = $urandom;
                if (k + 1 == int'(TO)) done = 1;
            end
            step();
            bus_ack = 1'b0;
            k++;
        end
        tests++;
        if (!done) begin
            fails++; $display("FAIL %s/req_bound: got %0d cycles want end by %0d", name, k, TO);
        end

        tests++;
        if ({bus_req, load_valid, bus_err} !== {1'b0, acked & r, ~acked}) begin
            fails++; $display("FAIL %s/done: got req,lv,berr=%b want %b", name,
                              {bus_req, load_valid, bus_err}, {1'b0, acked & r, ~acked});
        end
        if (acked && r) begin
            tests++;
            if ({load_data, load_rd} !== {exp_ld, rdn}) begin
                fails++; $display("FAIL %s/load: got data=%h rd=%0d want %h %0d", name,
                                  load_data, load_rd, exp_ld, rdn);
            end
        end else if (!acked) begin
            tests++;
            if (load_data !== 32'd0) begin
                fails++; $display("FAIL %s/timeout_data: got %h want 0", name, load_data);
            end
        end
        // A request presented during DONE must be ignored
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL %s/done_stall: got %b want 0", name, stall);
        end
        step();
        idle_inputs();
        tests++;
        if ({load_valid, bus_err, bus_req, access_err} !== 4'b0000) begin
            fails++; $display("FAIL %s/post_done: got lv,berr,req,aerr=%b want 0000", name,
                              {load_valid, bus_err, bus_req, access_err});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_valid, load_data, load_rd,
             access_err, bus_err, stall} !== '0) begin
            fails++; $display("FAIL reset/outputs: got req=%b addr=%h be=%b lv=%b ld=%h stall=%b want all 0",
                              bus_req, bus_addr, bus_be, load_valid, load_data, stall);
        end
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL reset/stall_in_rst: got %b want 0", stall);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_store_word();
        do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, 0, 32'h0, "sw");
    endtask

    task automatic test_load_sign();
        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd7, 0, 32'h80123456, "lb");
        do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd8, 1, 32'h80123456, "lbu");
        do_access(1'b1, 1'b1, 3'b001, 32'h102, 32'h5555, 5'd9, 0, 32'hBEEF1234, "lh_rw");
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd1, 0, 32'h0, "lh_mis");
        do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd1, 0, 32'h0, "f3_011");
        do_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd1, 0, 32'h0, "sw_mis");
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd3, 99, 32'h0, "lw_timeout");
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd4, int'(TO) - 1, 32'h12345678, "lw_late_ack");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 3'b000, 32'h3, 32'hAB, 5'd0, 0, 32'h0, "sb");
        do_access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd12, 0, 32'hCAFEF00D, "lw_b2b");
    endtask

    task automatic test_ack_ignored();
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        step();
        tests++;
        if ({bus_req, load_valid, bus_err} !== 3'b000) begin
            fails++; $display("FAIL idle_ack: got req,lv,berr=%b want 000", {bus_req, load_valid, bus_err});
        end
    endtask

    task automatic test_reset_mid();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
        step();
        idle_inputs();
        step();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus_req, stall, load_valid, bus_err} !== 4'b0000) begin
            fails++; $display("FAIL rst_mid/abort: got req,stall,lv,berr=%b want 0000",
                              {bus_req, stall, load_valid, bus_err});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        tests++;
        if ({bus_req, load_valid, bus_err} !== 3'b000) begin
            fails++; $display("FAIL rst_mid/after: got req,lv,berr=%b want 000",
                              {bus_req, load_valid, bus_err});
        end
        do_access(1'b1, 1'b0, 3'b101, 32'h86, 32'h0, 5'd21, 1, 32'h9ABC0000, "lhu_after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 5), $urandom, "rand");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_word();
        test_load_sign();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_ack_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
